// File: rtl/hash_table_pkg.sv
// Shared hash-table definitions: data-table address width and the
// free-list controller state encoding.
package hash_table_pkg;

    localparam int TABLE_ADDR_WIDTH = 4;
    localparam int TABLE_DEPTH      = 2 ** TABLE_ADDR_WIDTH;

    typedef enum logic {
        INIT_S  = 1'b0,
        READY_S = 1'b1
    } eps_state_e;

endpackage

// File: rtl/simple_ram.sv
// Single write port / registered read port RAM. A read that hits the
// address being written on the same edge returns the old word.
module simple_ram
    import hash_table_pkg::*;
#(
    parameter int AW = TABLE_ADDR_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [AW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [AW-1:0] rdata_o
);

    logic [AW-1:0] mem_q [2**AW];
    logic [AW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset so the head output is clean out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/empty_ptr_storage.sv
// Free-list of data-table addresses: self-initialising circular FIFO that
// hands out the oldest free address and takes back released ones.
module empty_ptr_storage
    import hash_table_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        srst_i,
    input  logic [TABLE_ADDR_WIDTH-1:0] add_addr_i,
    input  logic                        add_addr_en_i,
    input  logic                        del_addr_en_i,
    output logic [TABLE_ADDR_WIDTH-1:0] empty_addr_o,
    output logic                        empty_addr_val_o,
    output logic                        ready_o,
    output logic [TABLE_ADDR_WIDTH:0]   empty_cnt_o,
    output logic                        overflow_o,
    output logic                        underflow_o
);

    localparam int AW = TABLE_ADDR_WIDTH;
    localparam int CW = TABLE_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(TABLE_DEPTH);
    localparam logic [AW-1:0] ADDR_LAST = AW'(TABLE_DEPTH - 1);

    eps_state_e    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          fresh_q, fresh_d;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_wdata;
    logic [AW-1:0] ram_rdata;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        init_cnt_d = init_cnt_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        ram_we     = 1'b0;
        ram_waddr  = wr_ptr_q;
        ram_wdata  = add_addr_i;
        do_push    = 1'b0;
        do_pop     = 1'b0;

        if (srst_i) begin
            state_d    = INIT_S;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            init_cnt_d = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
        end else begin
            case (state_q)
                INIT_S: begin
                    ram_we     = 1'b1;
                    ram_waddr  = init_cnt_q;
                    ram_wdata  = init_cnt_q;
                    init_cnt_d = init_cnt_q + 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    count_d    = count_q + 1'b1;
                    if (del_addr_en_i) begin
                        unf_d = 1'b1;
                    end
                    if (init_cnt_q == ADDR_LAST) begin
                        state_d = READY_S;
                    end
                end
                READY_S: begin
                    // A full FIFO still accepts a push when a pop frees a slot.
                    do_push = add_addr_en_i && ((count_q != CNT_FULL) || del_addr_en_i);
                    do_pop  = del_addr_en_i && (count_q != '0);
                    if (add_addr_en_i && !del_addr_en_i && (count_q == CNT_FULL)) begin
                        ovf_d = 1'b1;
                    end
                    if (del_addr_en_i && (count_q == '0)) begin
                        unf_d = 1'b1;
                    end
                    if (do_push) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (do_pop) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                    count_d = count_q + CW'(do_push) - CW'(do_pop);
                end
                default: begin
                    state_d = INIT_S;
                end
            endcase
        end

        // The head read returns the pre-write word when it hits the slot being
        // written; such a head is stale until the next edge re-reads it.
        fresh_d = !(ram_we && (ram_waddr == rd_ptr_d));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= INIT_S;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            init_cnt_q <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            fresh_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            init_cnt_q <= init_cnt_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            fresh_q    <= fresh_d;
        end
    end

    simple_ram #(
        .AW (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    assign empty_addr_o     = ram_rdata;
    assign empty_addr_val_o = (state_q == READY_S) && (count_q != '0) && fresh_q;
    assign ready_o          = (state_q == READY_S);
    assign empty_cnt_o      = count_q;
    assign overflow_o       = ovf_q;
    assign underflow_o      = unf_q;

endmodule
